// File: rtl/uart_tx.sv
// 8N1 UART transmitter with a small power-of-two transmit FIFO.
// Frame timing is driven by a per-bit baud counter that restarts on every state entry.
module uart_tx #(
    parameter int CLK_DIV    = 868,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [7:0]                    wr_data,
    input  logic                          wr_valid,
    output logic                          wr_ready,
    output logic                          tx,
    output logic                          busy,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
    output logic                          irq
);

    localparam int PTR_W  = $clog2(FIFO_DEPTH);
    localparam int CNT_W  = PTR_W + 1;
    localparam int BAUD_W = $clog2(CLK_DIV);
    localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLK_DIV - 1);
    localparam logic [CNT_W-1:0]  CNT_FULL  = CNT_W'(FIFO_DEPTH);

    typedef enum logic [1:0] {IDLE = 2'd0, START = 2'd1, DATA = 2'd2, STOP = 2'd3} state_t;

    logic [7:0]        mem_r [FIFO_DEPTH];
    logic [PTR_W-1:0]  wr_ptr_r;
    logic [PTR_W-1:0]  rd_ptr_r;
    logic [CNT_W-1:0]  count_r;
    state_t            state_r;
    state_t            state_s;
    logic [BAUD_W-1:0] baud_r;
    logic [BAUD_W-1:0] baud_s;
    logic [2:0]        bit_r;
    logic [2:0]        bit_s;
    logic [7:0]        data_r;
    logic              tx_r;
    logic              tx_s;
    logic              irq_r;
    logic              irq_s;
    logic              push_s;
    logic              pop_s;
    logic              baud_done_s;
    logic              fifo_empty_s;

    assign fifo_empty_s = (count_r == CNT_W'(0));
    assign baud_done_s  = (baud_r == BAUD_LAST);
    assign push_s       = wr_valid && wr_ready;

    assign wr_ready   = (count_r != CNT_FULL);
    assign busy       = (state_r != IDLE) || !fifo_empty_s;
    assign fifo_count = count_r;
    assign tx         = tx_r;
    assign irq        = irq_r;

    // FIFO storage: data is only meaningful between the pointers, so no reset is needed.
    always_ff @(posedge clk) begin
        if (push_s) begin
            mem_r[wr_ptr_r] <= wr_data;
        end
    end

    // State register plus FIFO pointers, counters and registered line outputs.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r  <= IDLE;
            baud_r   <= '0;
            bit_r    <= 3'd0;
            data_r   <= 8'd0;
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
            count_r  <= '0;
            tx_r     <= 1'b1;
            irq_r    <= 1'b0;
        end else begin
            state_r <= state_s;
            baud_r  <= baud_s;
            bit_r   <= bit_s;
            tx_r    <= tx_s;
            irq_r   <= irq_s;
            if (pop_s) begin
                data_r   <= mem_r[rd_ptr_r];
                rd_ptr_r <= rd_ptr_r + PTR_W'(1);
            end
            if (push_s) begin
                wr_ptr_r <= wr_ptr_r + PTR_W'(1);
            end
            case ({push_s, pop_s})
                2'b10:   count_r <= count_r + CNT_W'(1);
                2'b01:   count_r <= count_r - CNT_W'(1);
                default: count_r <= count_r;
            endcase
        end
    end

    // Next-state logic; pop is gated on the registered count so a fresh push is never popped at once.
    always_comb begin
        state_s = state_r;
        baud_s  = baud_r + BAUD_W'(1);
        bit_s   = bit_r;
        pop_s   = 1'b0;
        case (state_r)
            IDLE: begin
                baud_s = '0;
                bit_s  = 3'd0;
                if (!fifo_empty_s) begin
                    pop_s   = 1'b1;
                    state_s = START;
                end else begin
                    state_s = IDLE;
                end
            end
            START: begin
                if (baud_done_s) begin
                    state_s = DATA;
                    baud_s  = '0;
                    bit_s   = 3'd0;
                end else begin
                    state_s = START;
                end
            end
            DATA: begin
                if (baud_done_s) begin
                    baud_s = '0;
                    if (bit_r == 3'd7) begin
                        state_s = STOP;
                    end else begin
                        bit_s = bit_r + 3'd1;
                    end
                end else begin
                    state_s = DATA;
                end
            end
            STOP: begin
                if (baud_done_s) begin
                    baud_s = '0;
                    bit_s  = 3'd0;
                    if (!fifo_empty_s) begin
                        pop_s   = 1'b1;
                        state_s = START;
                    end else begin
                        state_s = IDLE;
                    end
                end else begin
                    state_s = STOP;
                end
            end
            default: begin
                state_s = IDLE;
                baud_s  = '0;
                bit_s   = 3'd0;
            end
        endcase
    end

    // Output logic: next line level follows the next state so tx changes on the state-entry edge.
    always_comb begin
        tx_s  = 1'b1;
        irq_s = (state_r == STOP) && (state_s == IDLE);
        case (state_s)
            START:   tx_s = 1'b0;
            DATA:    tx_s = data_r[bit_s];
            default: tx_s = 1'b1;
        endcase
    end

endmodule

// File: tb/tb_uart_tx.sv
// Randomized and directed bench for uart_tx, checked against a frame-position model of the serial line.
module tb_uart_tx;

    localparam int CLK_DIV    = 4;
    localparam int FIFO_DEPTH = 4;
    localparam int FRAME      = 10 * CLK_DIV;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] wr_data;
    logic       wr_valid;
    logic       wr_ready;
    logic       tx;
    logic       busy;
    logic [2:0] fifo_count;
    logic       irq;

    int checks   = 0;
    int failures = 0;

    // Reference model: byte queue plus position (in cycles) inside the current frame, -1 when idle.
    logic [7:0] q[$];
    int         pos      = -1;
    logic [7:0] cur      = 8'h00;
    logic       exp_irq  = 1'b0;
    logic       accepted = 1'b0;
    int         irq_cnt  = 0;
    int         low_cnt  = 0;
    logic       saw_full = 1'b0;

    uart_tx #(.CLK_DIV(CLK_DIV), .FIFO_DEPTH(FIFO_DEPTH)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .wr_data    (wr_data),
        .wr_valid   (wr_valid),
        .wr_ready   (wr_ready),
        .tx         (tx),
        .busy       (busy),
        .fifo_count (fifo_count),
        .irq        (irq)
    );

    always #5 clk = ~clk;

    function automatic logic exp_tx();
        int b;
        if (pos < 0) return 1'b1;
        b = pos / CLK_DIV;
        if (b == 0) return 1'b0;
        if (b <= 8) return cur[b-1];
        return 1'b1;
    endfunction

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // One clock: drive inputs, advance the model on the edge, compare all outputs just after.
    task automatic step(input logic v, input logic [7:0] d, input logic rn);
        wr_valid = v;
        wr_data  = d;
        rst_n    = rn;
        @(posedge clk);
        if (!rn) begin
            q.delete();
            pos      = -1;
            exp_irq  = 1'b0;
            accepted = 1'b0;
        end else begin
            accepted = v && (q.size() < FIFO_DEPTH);
            exp_irq  = 1'b0;
            if (pos < 0) begin
                if (q.size() > 0) begin
                    cur = q.pop_front();
                    pos = 0;
                end
            end else begin
                pos++;
                if (pos == FRAME) begin
                    if (q.size() > 0) begin
                        cur = q.pop_front();
                        pos = 0;
                    end else begin
                        pos     = -1;
                        exp_irq = 1'b1;
                    end
                end
            end
            if (accepted) q.push_back(d);
        end
        #1;
        check_eq("tx", 32'(tx), 32'(exp_tx()));
        check_eq("irq", 32'(irq), 32'(exp_irq));
        check_eq("fifo_count", 32'(fifo_count), 32'(q.size()));
        check_eq("busy", 32'((pos >= 0) || (q.size() != 0)), 32'(busy));
        check_eq("wr_ready", 32'(wr_ready), 32'(q.size() < FIFO_DEPTH));
        if (irq) irq_cnt++;
        if (!tx) low_cnt++;
        if (!wr_ready) saw_full = 1'b1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 8'h00, 1'b1);
    endtask

    // Producer holds wr_valid until the byte is taken.
    task automatic send(input logic [7:0] d);
        int n = 0;
        do begin
            step(1'b1, d, 1'b1);
            n++;
        end while (!accepted && n < 200);
        check_eq("send_accept", 32'(accepted), 32'd1);
    endtask

    task automatic wait_pos(input int target);
        int n = 0;
        while (pos < target && n < 200) begin
            step(1'b0, 8'h00, 1'b1);
            n++;
        end
        check_eq("wait_pos", 32'(pos >= target), 32'd1);
    endtask

    initial begin
        logic       v;
        logic [7:0] d;
        logic       rn;

        // Reset state
        for (int i = 0; i < 3; i++) step(1'b0, 8'h00, 1'b0);
        check_eq("rst_tx", 32'(tx), 32'd1);
        check_eq("rst_ready", 32'(wr_ready), 32'd1);
        check_eq("rst_count", 32'(fifo_count), 32'd0);
        idle(2);

        // Single byte and start-bit latency
        irq_cnt = 0;
        send(8'h55);
        check_eq("lat_before", 32'(tx), 32'd1);
        step(1'b0, 8'h00, 1'b1);
        check_eq("lat_start", 32'(tx), 32'd0);
        idle(44);
        check_eq("single_irq", 32'(irq_cnt), 32'd1);
        check_eq("single_busy", 32'(busy), 32'd0);

        // Backpressure with six back-to-back bytes
        irq_cnt  = 0;
        saw_full = 1'b0;
        for (int i = 1; i <= 6; i++) send(8'(i));
        check_eq("bp_full_seen", 32'(saw_full), 32'd1);
        idle(6 * FRAME);
        check_eq("bp_irq", 32'(irq_cnt), 32'd1);

        // Chaining from the stop bit
        irq_cnt = 0;
        send(8'h00);
        wait_pos(9 * CLK_DIV);
        send(8'hA5);
        idle(2 * FRAME + 5);
        check_eq("chain_irq", 32'(irq_cnt), 32'd1);

        // Reset in the middle of data bit 3 with two bytes queued
        send(8'h11);
        send(8'h22);
        send(8'h33);
        wait_pos(4 * CLK_DIV + 1);
        check_eq("mid_queued", 32'(fifo_count), 32'd2);
        step(1'b0, 8'h00, 1'b0);
        check_eq("mid_tx", 32'(tx), 32'd1);
        check_eq("mid_count", 32'(fifo_count), 32'd0);
        check_eq("mid_irq", 32'(irq), 32'd0);
        irq_cnt = 0;
        low_cnt = 0;
        idle(3 * FRAME);
        check_eq("mid_no_irq", 32'(irq_cnt), 32'd0);
        check_eq("mid_no_frame", 32'(low_cnt), 32'd0);

        // Data extremes
        low_cnt = 0;
        send(8'h00);
        idle(FRAME + 5);
        check_eq("zero_low", 32'(low_cnt), 32'(9 * CLK_DIV));
        low_cnt = 0;
        send(8'hFF);
        idle(FRAME + 5);
        check_eq("ones_low", 32'(low_cnt), 32'(CLK_DIV));

        // Randomized traffic with occasional resets
        v = 1'b0;
        d = 8'h00;
        for (int i = 0; i < 3000; i++) begin
            if (!v && ($urandom % 3 == 0)) begin
                v = 1'b1;
                d = 8'($urandom);
            end
            rn = ($urandom % 600) != 0;
            step(v, d, rn);
            if (accepted || !rn) v = 1'b0;
        end
        idle(FIFO_DEPTH * FRAME + FRAME + 5);
        check_eq("final_busy", 32'(busy), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/uart_tx.md
UART_TX -- requirements
Module: uart_tx

Interface
REQ-001 SHALL have parameter CLK_DIV, default 868, meaning clock cycles per bit (100 MHz / 115200); legal values >= 2.
REQ-002 SHALL have parameter FIFO_DEPTH, default 4, meaning transmit FIFO entries; legal values are powers of 2 and >= 2.
REQ-003 SHALL have port clk, input, 1 bit: the single core clock; all state changes on its rising edge.
REQ-004 SHALL have port rst_n, input, 1 bit: synchronous, active-low reset.
REQ-005 SHALL have port wr_data, input, 8 bits: byte to transmit.
REQ-006 SHALL have port wr_valid, input, 1 bit: wr_data is valid.
REQ-007 SHALL have port wr_ready, output, 1 bit: FIFO can accept a byte.
REQ-008 SHALL have port tx, output, 1 bit: serial line, idle high.
REQ-009 SHALL have port busy, output, 1 bit: a frame is in progress or the FIFO is non-empty.
REQ-010 SHALL have port fifo_count, output, $clog2(FIFO_DEPTH)+1 bits: current FIFO occupancy.
REQ-011 SHALL have port irq, output, 1 bit: transmit-complete pulse, wired to interrupt code TRAP_CODE_UART0TX (17).

Function
REQ-012 SHALL use frame format 8N1: start bit (0), data bits LSB first, stop bit (1); each bit lasts exactly CLK_DIV cycles, and a frame lasts exactly 10*CLK_DIV cycles.
REQ-013 SHALL accept a byte on any rising edge where wr_valid && wr_ready; wr_ready SHALL equal !(fifo_count == FIFO_DEPTH), derived from registered count only.
REQ-014 SHALL drop nothing silently: writes while wr_ready = 0 have no effect, and wr_valid is held by the producer.
REQ-015 SHALL implement FSM states IDLE, START, DATA, STOP, using a bit-index counter (0-7) and a baud counter (0..CLK_DIV-1) that resets on every state entry.
REQ-016 SHALL, in IDLE with FIFO non-empty, pop the head into the shift register and enter START on the same edge; tx SHALL go low on that edge.
REQ-017 SHALL give a latency of exactly 2 edges from write to start bit: a byte written at edge k into an empty FIFO with the FSM in IDLE drives tx low after edge k+1.
REQ-018 SHALL transition START->DATA when the baud counter equals CLK_DIV-1, DATA->STOP after bit index 7 completes, and leave STOP when the baud counter equals CLK_DIV-1.
REQ-019 SHALL, on leaving STOP with the FIFO non-empty, pop and enter START directly, with no idle cycle between the stop bit and the next start bit.
REQ-020 SHALL, on leaving STOP with the FIFO empty, enter IDLE and assert irq for exactly that one cycle.
REQ-021 SHALL, when a push and a pop coincide, leave fifo_count unchanged and preserve data order (a push to an empty FIFO is never popped the same cycle).
REQ-022 SHALL wrap FIFO read and write pointers modulo FIFO_DEPTH.
REQ-023 SHALL compute busy = (state != IDLE) || (fifo_count != 0) combinationally from registers.

Reset
REQ-024 SHALL, while rst_n = 0 at a rising edge, set tx = 1, wr_ready = 1, busy = 0, irq = 0, fifo_count = 0, state = IDLE, and zero all counters and pointers.
REQ-025 SHALL abort a frame when reset is asserted mid-frame: tx returns high after that edge, FIFO contents are discarded, and no irq is generated.

Verification (CLK_DIV = 4, FIFO_DEPTH = 4)
REQ-026 SHALL cover single byte: write 0x55 at edge k -> tx low for edges k+1..k+4, then bits 1,0,1,0,1,0,1,0 at 4 cycles each, stop high through k+40; irq high one cycle after edge k+41; busy low after that.
REQ-027 SHALL cover backpressure: 6 consecutive writes (0x01..0x06) -> first byte popped at k+1, wr_ready low once fifo_count = 4, all 6 bytes sent in order as back-to-back frames of 40 cycles each, exactly one irq, after the last frame.
REQ-028 SHALL cover stop-bit chaining: write 0xA5 during the STOP of frame 0x00 -> 0xA5 start bit immediately follows the stop bit, with no irq between the frames.
REQ-029 SHALL cover reset mid-frame: rst_n low during DATA bit 3 with 2 bytes queued -> tx = 1, fifo_count = 0, irq = 0 after the edge; no further frames until a new write.
REQ-030 SHALL cover data extremes: 0x00 and 0xFF -> tx low for 36 cycles then high for 4 (0x00); tx low for 4 cycles then high for 36 (0xFF).
